// File: rtl/spawn_pkg.sv
// spawn_pkg: shared types and constants for the character spawner.
// Holds the FSM states, ASCII bases, LFSR taps, retry limit and LFSR helpers.
package spawn_pkg;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_DRAW,
        ST_CHECK,
        ST_OFFER
    } state_t;

    localparam logic [7:0]  ASCII_ALPHA = 8'h41;
    localparam logic [7:0]  ASCII_DIGIT = 8'h30;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [1:0]  RETRY_LIMIT = 2'd3;

    // Right-shifting Galois step: feedback bit is the bit shifted out.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// spawn_lfsr: 16-bit Galois LFSR, advances one step when step=1.
// Ports: clk, rst (async high), step, seed (reset value), value (state).
module spawn_lfsr
    import spawn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= seed_fix(seed);
        end else if (step) begin
            value <= lfsr_advance(value);
        end
    end

endmodule

// File: rtl/spawn_gen.sv
// spawn_gen: periodic random spawner for falling characters (valid/ready out).
// Ports: clk, rst, en, out_ready in; out_valid/char/col/speed, spawn_count out.
// Macro SPAWN_DIGITS_EN widens the alphabet from A-Z to A-Z plus 0-9.
module spawn_gen
    import spawn_pkg::*;
#(
    parameter int          PERIOD_CYCLES = 25000000,
    parameter int          NUM_COLS      = 40,
    parameter int          COL_STEP      = 16,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_char,
    output logic [9:0] out_col,
    output logic [2:0] out_speed,
    output logic [7:0] spawn_count
);

    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    retry;
    logic [5:0]    cand_slot;
    logic [5:0]    hist_slot [8];
    logic [7:0]    hist_vld;
    logic [2:0]    wr_ptr;

    logic [15:0]   lfsr_val;
    logic [15:0]   lfsr_nxt;
    logic [5:0]    slot_raw;
    logic [5:0]    slot_nx;
    logic [7:0]    char_nx;
    logic [2:0]    speed_nx;
    logic          hit;

    spawn_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (state == ST_DRAW),
        .seed  (SEED),
        .value (lfsr_val)
    );

    // Candidate fields come from the value the LFSR takes at the end of DRAW.
    assign lfsr_nxt = lfsr_advance(lfsr_val);
    assign slot_raw = lfsr_nxt[5:0];
    assign slot_nx  = (slot_raw >= 6'(NUM_COLS)) ?
                      slot_raw - 6'(NUM_COLS) : slot_raw;
    assign speed_nx = {1'b0, lfsr_nxt[15:14]} + 3'd1;

`ifdef SPAWN_DIGITS_EN
    logic [5:0] idx6;
    logic [1:0] unused_bits;
    assign unused_bits = lfsr_nxt[7:6];

    always_comb begin
        idx6 = lfsr_nxt[13:8];
        if (idx6 >= 6'd36) idx6 = idx6 - 6'd36;
        if (idx6 >= 6'd36) idx6 = idx6 - 6'd36;
        if (idx6 < 6'd26) char_nx = ASCII_ALPHA + {2'b00, idx6};
        else              char_nx = ASCII_DIGIT + {2'b00, idx6 - 6'd26};
    end
`else
    logic [4:0] idx5;
    logic [2:0] unused_bits;
    assign unused_bits = {lfsr_nxt[13], lfsr_nxt[7:6]};

    always_comb begin
        idx5 = lfsr_nxt[12:8];
        if (idx5 >= 5'd26) idx5 = idx5 - 5'd26;
        char_nx = ASCII_ALPHA + {3'b000, idx5};
    end
`endif

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (hist_vld[i] && hist_slot[i] == cand_slot) hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_WAIT;
            cnt         <= '0;
            retry       <= '0;
            cand_slot   <= '0;
            hist_vld    <= '0;
            wr_ptr      <= '0;
            out_valid   <= 1'b0;
            out_char    <= '0;
            out_col     <= '0;
            out_speed   <= '0;
            spawn_count <= '0;
            for (int i = 0; i < 8; i++) hist_slot[i] <= '0;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    if (en) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= ST_DRAW;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DRAW: begin
                    cand_slot <= slot_nx;
                    out_char  <= char_nx;
                    out_col   <= 10'(int'(slot_nx) * COL_STEP);
                    out_speed <= speed_nx;
                    state     <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (hit && retry < RETRY_LIMIT) begin
                        retry <= retry + 1'b1;
                        state <= ST_DRAW;
                    end else begin
                        out_valid <= 1'b1;
                        state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (out_ready) begin
                        out_valid         <= 1'b0;
                        hist_slot[wr_ptr] <= cand_slot;
                        hist_vld[wr_ptr]  <= 1'b1;
                        wr_ptr            <= wr_ptr + 1'b1;
                        spawn_count       <= spawn_count + 1'b1;
                        retry             <= '0;
                        state             <= ST_WAIT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spawn_gen.sv
// tb_spawn_gen: randomized self-checking bench for spawn_gen.
// Reference model draws descriptors with plain arithmetic and a history queue.
module tb_spawn_gen;

    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       out_ready = 1'b0;

    logic       out_valid, z_valid, o_valid;
    logic [7:0] out_char, z_char, o_char;
    logic [9:0] out_col, z_col, o_col;
    logic [2:0] out_speed, z_speed, o_speed;
    logic [7:0] spawn_count, z_count, o_count;

    spawn_gen #(.PERIOD_CYCLES(P)) dut (
        .clk(clk), .rst(rst), .en(en), .out_ready(out_ready),
        .out_valid(out_valid), .out_char(out_char), .out_col(out_col),
        .out_speed(out_speed), .spawn_count(spawn_count)
    );

    spawn_gen #(.PERIOD_CYCLES(P), .SEED(16'h0000)) dut_z (
        .clk(clk), .rst(rst), .en(en), .out_ready(out_ready),
        .out_valid(z_valid), .out_char(z_char), .out_col(z_col),
        .out_speed(z_speed), .spawn_count(z_count)
    );

    spawn_gen #(.PERIOD_CYCLES(P), .SEED(16'h0001)) dut_o (
        .clk(clk), .rst(rst), .en(en), .out_ready(out_ready),
        .out_valid(o_valid), .out_char(o_char), .out_col(o_col),
        .out_speed(o_speed), .spawn_count(o_count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] m_lfsr;
    int          m_hist[$];
    int          m_count;
    int          digits_seen = 0;
    int          s1_col, s1_ch, s1_spd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] v);
        if (v % 2 == 1) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    function automatic bit in_hist(input int slot);
        foreach (m_hist[i]) if (m_hist[i] == slot) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset(input logic [15:0] seed);
        m_lfsr = (seed == 0) ? 16'h0001 : seed;
        m_hist.delete();
        m_count = 0;
    endtask

    task automatic model_draw(output int r, output int col,
                              output int ch, output int spd);
        int slot, idx;
        r = 0;
        while (1) begin
            m_lfsr = m_step(m_lfsr);
            slot = (m_lfsr & 63) % 40;
            if (r < 3 && in_hist(slot)) r++;
            else break;
        end
`ifdef SPAWN_DIGITS_EN
        idx = ((m_lfsr >> 8) & 63) % 36;
        ch = (idx < 26) ? 65 + idx : 48 + idx - 26;
`else
        idx = ((m_lfsr >> 8) & 31) % 26;
        ch = 65 + idx;
`endif
        spd = (m_lfsr >> 14) + 1;
        col = slot * 16;
    endtask

    task automatic wait_valid(input int exp_edges);
        int n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) break;
        end
        chk("latency", n, exp_edges);
    endtask

    task automatic check_desc(input int col, input int ch, input int spd);
        chk("char", out_char, ch);
        chk("col", out_col, col);
        chk("speed", out_speed, spd);
        chk("col_align", out_col % 16, 0);
        chk("col_range", out_col < 640, 1);
        chk("spd_range", out_speed >= 1 && out_speed <= 4, 1);
`ifdef SPAWN_DIGITS_EN
        chk("char_range", (out_char >= 8'h41 && out_char <= 8'h5A) ||
                          (out_char >= 8'h30 && out_char <= 8'h39), 1);
`else
        chk("char_range", out_char >= 8'h41 && out_char <= 8'h5A, 1);
`endif
        if (out_char >= 8'h30 && out_char <= 8'h39) digits_seen++;
    endtask

    task automatic do_spawn(input int hold, input bit first);
        int r, col, ch, spd;
        model_draw(r, col, ch, spd);
        wait_valid(10 + 2 * r);
        check_desc(col, ch, spd);
        if (first) begin
            chk("seed0_valid", z_valid, 1);
            chk("seed0_desc", {z_char, z_col, z_speed},
                {8'(s1_ch), 10'(s1_col), 3'(s1_spd)});
            chk("seed1_desc", {o_char, o_col, o_speed},
                {8'(s1_ch), 10'(s1_col), 3'(s1_spd)});
        end
        for (int i = 0; i < hold; i++) begin
            en = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_desc", {out_char, out_col, out_speed},
                {8'(ch), 10'(col), 3'(spd)});
            chk("hold_count", spawn_count, m_count % 256);
        end
        en = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        m_count++;
        m_hist.push_back(col / 16);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        chk("count", spawn_count, m_count % 256);
        chk("valid_drop", out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, col, ch, spd;
        m_reset(16'h0001);
        model_draw(r, s1_col, s1_ch, s1_spd);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_char", out_char, 0);
        chk("rst_col", out_col, 0);
        chk("rst_speed", out_speed, 0);
        chk("rst_count", spawn_count, 0);
        chk("rst_z_valid", z_valid, 0);

        m_reset(16'hACE1);
        rst = 1'b0;
        do_spawn(50, 1'b1);
        for (int s = 1; s < 300; s++) do_spawn($urandom_range(0, 3), 1'b0);
        chk("wrap44", spawn_count, 44);

        model_draw(r, col, ch, spd);
        wait_valid(10 + 2 * r);
        check_desc(col, ch, spd);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", spawn_count, 0);
        chk("midrst_char", out_char, 0);
        @(negedge clk);
        rst = 1'b0;
        m_reset(16'hACE1);
        do_spawn(2, 1'b1);
        for (int s = 1; s < 200; s++) do_spawn($urandom_range(0, 3), 1'b0);

`ifdef SPAWN_DIGITS_EN
        chk("digits_seen", digits_seen > 0, 1);
`else
        chk("digits_seen", digits_seen, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
